adder_accum: RTL and testbench

//  Streaming multi-operand accumulator that sits directly upstream of the 32-bit ripple adder (adder32).
//  It sequences a packet of 32-bit operands through one adder32 instance (cin=0) into a running sum.
//  It registers the sum, the count of adder carry-outs and the operand count, then presents them on
//  a valid/ready output. Used wherever a packet of words must be summed to a 32-bit total plus overflow info.

---
 rtl/adder_accum.sv | 136 +++++++++++++
 tb/tb_adder_accum.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_accum.sv
// Streaming multi-operand accumulator: sums a packet of 32-bit words through one ripple adder32.
// Build option: define ADDER_ACCUM_SAT_EN to clamp the sum at 32'hFFFF_FFFF on the first carry-out.

module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [32:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 32; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[32];
    end
endmodule

module adder_accum #(
    parameter int CNT_W   = 8,
    parameter int CARRY_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_sum,
    output logic [CARRY_W-1:0] out_carry,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_ovf,
    output logic [1:0]         dbg_state
);
    // Handshakes: a beat transfers on a rising edge where valid && ready; the producer holds
    // valid and its payload stable until that edge, and ready never depends on valid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [31:0]         acc;
    logic [CARRY_W-1:0]  carry_cnt;
    logic [CNT_W-1:0]    op_cnt;
    logic                ovf;
    logic [31:0]         add_sum;
    logic                add_cout;
    logic                accept;
    logic                release_out;

    adder32 u_adder (
        .a    (acc),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign accept      = in_valid && in_ready;
    assign release_out = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = in_last ? DONE : ACCUM;
            ACCUM:   if (accept && in_last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (state)
            DONE:    begin in_ready = 1'b0; out_valid = 1'b1; end
            default: begin in_ready = 1'b1; out_valid = 1'b0; end
        endcase
    end

    // Packet state clears on the output handshake so IDLE always starts from a zero sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            carry_cnt <= '0;
            op_cnt    <= '0;
            ovf       <= 1'b0;
        end else if (release_out) begin
            acc       <= '0;
            carry_cnt <= '0;
            op_cnt    <= '0;
            ovf       <= 1'b0;
        end else if (accept) begin
            if (op_cnt != {CNT_W{1'b1}}) op_cnt <= op_cnt + 1'b1;
`ifdef ADDER_ACCUM_SAT_EN
            // Once clamped, the sum is frozen; carry_cnt deliberately stays zero.
            if (!ovf) begin
                if (add_cout) begin
                    acc <= 32'hFFFF_FFFF;
                    ovf <= 1'b1;
                end else begin
                    acc <= add_sum;
                end
            end
`else
            acc <= add_sum;
            if (add_cout) begin
                ovf <= 1'b1;
                if (carry_cnt != {CARRY_W{1'b1}}) carry_cnt <= carry_cnt + 1'b1;
            end
`endif
        end
    end

    assign out_sum   = acc;
    assign out_carry = carry_cnt;
    assign out_count = op_cnt;
    assign out_ovf   = ovf;
    assign dbg_state = state;
endmodule

// File: tb/tb_adder_accum.sv
// Self-checking bench for adder_accum: directed steps plus random packets against a 64-bit sum model.
// Honours ADDER_ACCUM_SAT_EN in the same way as the design.

module tb_adder_accum;
    localparam int W = 49;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic [7:0]  out_carry;
    logic [7:0]  out_count;
    logic        out_ovf;
    logic [1:0]  dbg_state;

    logic [W-1:0] exp_q[$];
    int           checks;
    int           failures;
    logic [63:0]  m_sum;
    int           m_cnt;
    logic         rand_ready;

    adder_accum #(.CNT_W(8), .CARRY_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] make_exp(input logic [63:0] s, input int cnt);
        logic [31:0] hi;
        logic [7:0]  c_sat;
        logic [7:0]  n_sat;
        logic        ov;
        hi    = s[63:32];
        c_sat = (hi > 255) ? 8'hFF : hi[7:0];
        n_sat = (cnt > 255) ? 8'hFF : cnt[7:0];
        ov    = (hi != 0);
`ifdef ADDER_ACCUM_SAT_EN
        return {(ov ? 32'hFFFF_FFFF : s[31:0]), 8'h00, n_sat, ov};
`else
        return {s[31:0], c_sat, n_sat, ov};
`endif
    endfunction

    // driver tasks
    task automatic send_word(input logic [31:0] d, input logic l);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_timeout", 64'(waited < 1000), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 'x;
        in_last  = 1'b0;
        m_sum += {32'h0, d};
        m_cnt++;
        if (l) begin
            exp_q.push_back(make_exp(m_sum, m_cnt));
            m_sum = '0;
            m_cnt = 0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outputs", {out_sum, out_carry, out_count, out_ovf}, 64'd0);
        exp_q.delete();
        m_sum = '0;
        m_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // scoreboard: compare on each output handshake, and check outputs hold while stalled
    logic         stall_prev;
    logic [W-1:0] held;
    initial begin
        stall_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    chk("hold_stable", {out_valid, out_sum, out_carry, out_count, out_ovf}, {1'b1, held});
                if (out_valid && out_ready) begin
                    chk("exp_q_nonempty", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0)
                        chk("result", {out_sum, out_carry, out_count, out_ovf}, exp_q.pop_front());
                end
                stall_prev = out_valid && !out_ready;
                held       = {out_sum, out_carry, out_count, out_ovf};
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        checks     = 0;
        failures   = 0;
        m_sum      = '0;
        m_cnt      = 0;
        rand_ready = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 'x;
        in_last    = 1'b0;
        out_ready  = 1'b0;

        #3;
        chk("init_in_ready", 64'(in_ready), 64'd1);
        chk("init_out_valid", 64'(out_valid), 64'd0);
        chk("init_outputs", {out_sum, out_carry, out_count, out_ovf}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // basic packet and result latency
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        chk("pre_last_valid", 64'(out_valid), 64'd0);
        send_word(32'd3, 1'b1);
        chk("latency_valid", 64'(out_valid), 64'd1);
        chk("sum6", 64'(out_sum), 64'd6);
        chk("count3", 64'(out_count), 64'd3);
        out_ready = 1'b1;
        wait_drain();

        // carry-out packet
        out_ready = 1'b0;
        send_word(32'hFFFF_FFFF, 1'b0);
        send_word(32'h0000_0002, 1'b1);
`ifdef ADDER_ACCUM_SAT_EN
        chk("carry_sum", 64'(out_sum), 64'hFFFF_FFFF);
        chk("carry_cnt", 64'(out_carry), 64'd0);
`else
        chk("carry_sum", 64'(out_sum), 64'd1);
        chk("carry_cnt", 64'(out_carry), 64'd1);
`endif
        chk("carry_ovf", 64'(out_ovf), 64'd1);
        out_ready = 1'b1;
        wait_drain();

        // backpressure with a stalled next word
        out_ready = 1'b0;
        send_word(32'd5, 1'b0);
        send_word(32'd6, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'd100;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_sum", 64'(out_sum), 64'd11);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_after_hs_count", 64'(out_count), 64'd0);
        send_word(32'd100, 1'b1);
        wait_drain();

        // async reset while holding a result
        out_ready = 1'b0;
        send_word(32'd9, 1'b1);
        chk("done_before_rst", 64'(out_valid), 64'd1);
        pulse_reset();

        // reset mid-packet, then a single-word packet
        send_word(32'd10, 1'b0);
        send_word(32'd20, 1'b0);
        pulse_reset();
        send_word(32'd7, 1'b1);
        chk("single_sum", 64'(out_sum), 64'd7);
        chk("single_count", 64'(out_count), 64'd1);
        chk("single_carry", 64'(out_carry), 64'd0);
        out_ready = 1'b1;
        wait_drain();

        // counter saturation: 300 all-ones words
        for (int i = 0; i < 300; i++) send_word(32'hFFFF_FFFF, (i == 299));
        wait_drain();

        // random packets with valid/ready gaps
        rand_ready = 1'b1;
        for (int p = 0; p < 200; p++) begin
            int n;
            n = $urandom_range(1, 20);
            for (int k = 0; k < n; k++) begin
                logic [31:0] d;
                d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom;
                send_word(d, (k == n - 1));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        wait_drain();
        rand_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
